mem_access_ctrl: RTL and testbench

Multicycle sequencer that sits between the CPU control unit and the unified word-addressed memory. It executes byte, half and word loads and stores of one access. It drives the memory address, write strobe and write data. For loads it captures the returned word and delivers the selected lane zero-extended. Sub-word stores are performed as read-modify-write, since memory only writes whole words.

---
 rtl/mem_ctrl_pkg.sv | 19 +
 rtl/lane_align.sv | 32 +++
 rtl/mem_access_ctrl.sv | 142 ++++++++++++++
 tb/tb_mem_access_ctrl.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared encodings for the memory access sequencer: size codes and FSM states.
// ERR state is only present when MEM_ALIGN_CHECK_EN is defined.
package mem_ctrl_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

`ifdef MEM_ALIGN_CHECK_EN
    typedef enum logic [2:0] {
        ST_IDLE, ST_RD_WAIT, ST_LATCH, ST_WR, ST_DONE, ST_ERR
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE, ST_RD_WAIT, ST_LATCH, ST_WR, ST_DONE
    } state_t;
`endif

endpackage

// File: rtl/lane_align.sv
// lane_align: zero-extending lane extract and sub-word merge into a full word.
// Latency: combinational, 0 cycles.
// Backpressure: none, pure function of its inputs.
module lane_align
    import mem_ctrl_pkg::*;
(
    input  logic [31:0] ext_word,
    input  logic [31:0] old_word,
    input  logic [31:0] new_data,
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    output logic [31:0] extract,
    output logic [31:0] merged
);

    logic [4:0]  shamt;
    logic [31:0] lane_mask;
    logic [31:0] shifted;

    always_comb begin
        shamt = {offset, 3'b000};
        case (size)
            SIZE_BYTE: lane_mask = 32'h0000_00FF;
            SIZE_HALF: lane_mask = 32'h0000_FFFF;
            default:   lane_mask = 32'hFFFF_FFFF;
        endcase
        shifted = ext_word >> shamt;
        extract = shifted & lane_mask;
        merged  = (old_word & ~(lane_mask << shamt)) | ((new_data & lane_mask) << shamt);
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: byte/half/word load-store sequencer, RMW for sub-word stores; MEM_ALIGN_CHECK_EN adds alignment trap.
// Latency: load MEM_LAT+2, word store 2, sub-word store MEM_LAT+3 cycles from accepted start.
// Backpressure: start honoured only in IDLE (busy low); requests arriving otherwise are dropped.
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int MEM_LAT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        is_store,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    input  logic [31:0] mem_rdata,
    output logic [31:0] mem_addr,
    output logic        mem_wr,
    output logic [31:0] mem_wdata,
    output logic [31:0] load_data,
    output logic        busy,
`ifdef MEM_ALIGN_CHECK_EN
    output logic        align_exc,
`endif
    output logic        done
);

    localparam int             CW       = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(MEM_LAT - 1);

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic          req_store;
    logic [1:0]    req_size;
    logic [1:0]    req_off;
    logic [31:0]   req_data;
    logic [31:0]   mdr;
    logic [31:0]   ext_val;
    logic [1:0]    size_n;
    logic [1:0]    off_n;
`ifdef MEM_ALIGN_CHECK_EN
    logic          misalign;
`endif

    // Size 11 behaves as word; unused low offset bits are masked off.
    always_comb begin
        size_n = (size == 2'b11) ? SIZE_WORD : size;
        case (size_n)
            SIZE_BYTE: off_n = addr[1:0];
            SIZE_HALF: off_n = {addr[1], 1'b0};
            default:   off_n = 2'b00;
        endcase
`ifdef MEM_ALIGN_CHECK_EN
        misalign = ((size_n == SIZE_HALF) && addr[0]) ||
                   ((size_n == SIZE_WORD) && (addr[1:0] != 2'b00));
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b1;
        done      = 1'b0;
        mem_wr    = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
        align_exc = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    if (is_store && (size_n == SIZE_WORD)) state_nxt = ST_WR;
                    else                                   state_nxt = ST_RD_WAIT;
`ifdef MEM_ALIGN_CHECK_EN
                    if (misalign) state_nxt = ST_ERR;
`endif
                end
            end
            ST_RD_WAIT: if (cnt == CNT_LAST) state_nxt = ST_LATCH;
            ST_LATCH:   state_nxt = req_store ? ST_WR : ST_DONE;
            ST_WR: begin
                mem_wr    = 1'b1;
                state_nxt = ST_DONE;
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
`ifdef MEM_ALIGN_CHECK_EN
            ST_ERR: begin
                align_exc = 1'b1;
                state_nxt = ST_IDLE;
            end
`endif
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= '0;
            req_store <= 1'b0;
            req_size  <= SIZE_BYTE;
            req_off   <= 2'b00;
            req_data  <= 32'h0;
            mem_addr  <= 32'h0;
            mdr       <= 32'h0;
            load_data <= 32'h0;
        end else begin
            if ((state == ST_IDLE) && start) begin
                req_store <= is_store;
                req_size  <= size_n;
                req_off   <= off_n;
                req_data  <= store_data;
                mem_addr  <= {addr[31:2], 2'b00};
            end
            if (state == ST_RD_WAIT) cnt <= (cnt == CNT_LAST) ? '0 : cnt + CW'(1);
            else                     cnt <= '0;
            // Read data is valid during LATCH; loads publish their lane on DONE entry.
            if (state == ST_LATCH) begin
                mdr <= mem_rdata;
                if (!req_store) load_data <= ext_val;
            end
        end
    end

    // Write word is decoded from registered request and MDR, so no input reaches it combinationally.
    lane_align u_lane_align (
        .ext_word (mem_rdata),
        .old_word (mdr),
        .new_data (req_data),
        .size     (req_size),
        .offset   (req_off),
        .extract  (ext_val),
        .merged   (mem_wdata)
    );

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomised bench for mem_access_ctrl against a cycle-budget and byte-lane reference model.
// Memory model returns junk until the address has been held MEM_LAT cycles.
module tb_mem_access_ctrl;

    localparam int L = 2;
    localparam int W = 16;
`ifdef MEM_ALIGN_CHECK_EN
    localparam bit ALIGN_ON = 1'b1;
`else
    localparam bit ALIGN_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, start, is_store;
    logic [1:0]  size;
    logic [31:0] addr, store_data, mem_rdata, mem_addr, mem_wdata, load_data;
    logic        mem_wr, busy, done;
`ifdef MEM_ALIGN_CHECK_EN
    logic        align_exc;
`endif

    always #5 clk = ~clk;

    mem_access_ctrl #(.MEM_LAT(L)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .is_store   (is_store),
        .size       (size),
        .addr       (addr),
        .store_data (store_data),
        .mem_rdata  (mem_rdata),
        .mem_addr   (mem_addr),
        .mem_wr     (mem_wr),
        .mem_wdata  (mem_wdata),
        .load_data  (load_data),
        .busy       (busy),
`ifdef MEM_ALIGN_CHECK_EN
        .align_exc  (align_exc),
`endif
        .done       (done)
    );

    logic [31:0] mem_env [256];
    logic [31:0] ref_mem [256];
    int          age = 0;

    always @(posedge clk) begin
        if (reset) mem_env <= ref_mem;
        else if (mem_wr) mem_env[mem_addr[9:2]] <= mem_wdata;
        age <= busy ? age + 1 : 0;
    end

    assign mem_rdata = (age >= L) ? mem_env[mem_addr[9:2]] : 32'h0BAD_F00D;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_ld = 32'h0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One request, start held for `hold` edges; expected timeline built from per-type durations.
    task automatic run(input bit st, input logic [1:0] sz, input logic [31:0] a,
                       input logic [31:0] sd, input int hold);
        logic [31:0] dm, wm, bm, em, wd_seen, addr1;
        logic [31:0] edm, ewm, ebm, eem, ewd, old, val;
        int          esz, off, n, dur, s;
        bit          mis;
        logic [7:0]  wi;
        dm = 0; wm = 0; bm = 0; em = 0; wd_seen = 0; addr1 = 0;
        edm = 0; ewm = 0; ebm = 0; eem = 0; ewd = 0;
        esz = (sz == 2'b11) ? 2 : int'(sz);
        mis = ALIGN_ON && ((esz == 1 && a[0]) || (esz == 2 && a[1:0] != 2'b00));
        off = (esz == 0) ? int'(a[1:0]) : (esz == 1) ? 2 * int'(a[1]) : 0;
        n   = (esz == 0) ? 1 : (esz == 1) ? 2 : 4;
        wi  = a[9:2];
        if (mis)           dur = 1;
        else if (!st)      dur = L + 2;
        else if (esz == 2) dur = 2;
        else               dur = L + 3;
        s = 0;
        while (s < hold) begin
            for (int c = s + 1; c <= s + dur; c++) ebm[c] = 1'b1;
            if (mis) eem[s + 1] = 1'b1;
            else begin
                edm[s + dur] = 1'b1;
                if (st) ewm[s + dur - 1] = 1'b1;
            end
            s = s + dur + 1;
        end
        old = ref_mem[wi];
        if (!mis) begin
            if (!st) begin
                val = 0;
                for (int i = 0; i < n; i++)
                    val = val | (((old >> (8 * (off + i))) & 32'hFF) << (8 * i));
                exp_ld = val;
            end else begin
                for (int b = 0; b < 4; b++) begin
                    if (b >= off && b < off + n) ewd = ewd | (((sd >> (8 * (b - off))) & 32'hFF) << (8 * b));
                    else                         ewd = ewd | (old & (32'hFF << (8 * b)));
                end
                ref_mem[wi] = ewd;
            end
        end
        @(negedge clk);
        start = 1'b1; is_store = st; size = sz; addr = a; store_data = sd;
        for (int k = 1; k < W; k++) begin
            @(negedge clk);
            dm[k] = done; wm[k] = mem_wr; bm[k] = busy;
`ifdef MEM_ALIGN_CHECK_EN
            em[k] = align_exc;
`endif
            if (mem_wr) wd_seen = mem_wdata;
            if (k == 1) addr1 = mem_addr;
            start = (k < hold);
        end
        chk("busy_mask", bm, ebm);
        chk("done_mask", dm, edm);
        chk("wr_mask", wm, ewm);
        chk("err_mask", em, eem);
        if (!mis) chk("mem_addr", addr1, {a[31:2], 2'b00});
        if (st && !mis) chk("wdata", wd_seen, ewd);
        chk("load_data", load_data, exp_ld);
    endtask

    initial begin
        int dcnt;
        reset = 1'b1; start = 1'b0; is_store = 1'b0; size = 2'b00; addr = 0; store_data = 0;
        for (int i = 0; i < 256; i++) ref_mem[i] = $urandom;
        ref_mem[32'h100 >> 2] = 32'hDEAD_BEEF;
        ref_mem[32'h200 >> 2] = 32'h1122_3344;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_done", {31'b0, done}, 0);
        chk("rst_wr", {31'b0, mem_wr}, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_load", load_data, 0);
`ifdef MEM_ALIGN_CHECK_EN
        chk("rst_exc", {31'b0, align_exc}, 0);
`endif
        reset = 1'b0;

        // Reset during RD_WAIT aborts the load with no done and no load_data change.
        @(negedge clk);
        start = 1'b1; is_store = 1'b0; size = 2'b10; addr = 32'h100;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst_abort_busy", {31'b0, busy}, 0);
        dcnt = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        chk("rst_abort_done", dcnt, 0);
        chk("rst_abort_load", load_data, 0);

        run(1'b0, 2'b10, 32'h100, 32'h0, 1);
        run(1'b0, 2'b00, 32'h103, 32'h0, 1);
        run(1'b0, 2'b01, 32'h102, 32'h0, 1);
        run(1'b1, 2'b01, 32'h202, 32'h0000_CAFE, 1);
        run(1'b1, 2'b10, 32'h301, 32'hA5A5_A5A5, 1);
        run(1'b0, 2'b10, 32'h100, 32'h0, 10);

        for (int t = 0; t < 80; t++) begin
            bit          st;
            logic [1:0]  sz;
            logic [31:0] a;
            int          h;
            st = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            a  = $urandom_range(0, 1023);
            h  = (!st && $urandom_range(0, 7) == 0) ? int'($urandom_range(2, 8)) : 1;
            run(st, sz, a, $urandom, h);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
